// File: rtl/cocc_arith_pkg.sv
// Shared definitions for the arithmetic extension blocks: divider FSM states,
// default operand width and the iteration-counter width helper.
package cocc_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DIV_W = 8;

  // Counter must hold 0..2*width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(2 * width + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DIV_W);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
  import cocc_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] r_next_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] b_ext;

  always_comb begin
    shifted  = {r_i, dvd_bit_i};
    b_ext    = {1'b0, b_i};
    q_bit_c  = (shifted >= b_ext);
    // A successful subtract always leaves the result below b, so WIDTH bits suffice.
    r_next_c = q_bit_c ? WIDTH'(shifted - b_ext) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div.sv
// Sequential unsigned 2W/W restoring divider with start/busy/done handshake;
// one quotient bit per clock, results registered on entry to DONE.
module div
  import cocc_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_rem,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DW      = 2 * WIDTH;
  localparam int unsigned LOC_CNT = cnt_width(WIDTH);
  localparam logic [LOC_CNT-1:0] LAST_STEP = LOC_CNT'(DW - 1);

  state_e               state_q, state_d;
  logic [LOC_CNT-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [DW-1:0]        dvd_q, dvd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     orem_q, orem_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     step_r;
  logic                 step_q_bit;
  logic [DW-1:0]        dvd_shift;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i       (rem_q),
    .dvd_bit_i (dvd_q[DW-1]),
    .b_i       (b_q),
    .r_next_c  (step_r),
    .q_bit_c   (step_q_bit)
  );

  // Dividend shifts out the top while quotient bits fill in from the bottom.
  assign dvd_shift = {dvd_q[DW-2:0], step_q_bit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    orem_d  = orem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (in_b != '0) begin
            b_d     = in_b;
            dvd_d   = {in_hi, in_lo};
            rem_d   = '0;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            hi_d    = '1;
            lo_d    = '1;
            orem_d  = '0;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        rem_d = step_r;
        dvd_d = dvd_shift;
        cnt_d = cnt_q + LOC_CNT'(1);
        if (cnt_q == LAST_STEP) begin
          hi_d    = dvd_shift[DW-1:WIDTH];
          lo_d    = dvd_shift[WIDTH-1:0];
          orem_d  = step_r;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      orem_q  <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      orem_q  <= orem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_hi   = hi_q;
  assign out_lo   = lo_q;
  assign out_rem  = orem_q;
  assign div_zero = dz_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_div.sv
// Bench for the sequential divider: directed corner cases plus random operands
// checked against plain integer division.
module tb_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_hi, in_lo, in_b;
  logic [7:0] out_hi, out_lo, out_rem;
  logic       div_zero, busy, done;

  int n_cmp = 0;
  int n_mis = 0;

  div #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_hi    (in_hi),
    .in_lo    (in_lo),
    .in_b     (in_b),
    .out_hi   (out_hi),
    .out_lo   (out_lo),
    .out_rem  (out_rem),
    .div_zero (div_zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one division and check latency, busy, results and the done pulse.
  task automatic run_op(input logic [7:0] hi, input logic [7:0] lo,
                        input logic [7:0] b, input bit repulse);
    logic [15:0] dvd;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dz;
    int          exp_lat;
    int          n;
    dvd = {hi, lo};
    if (b == 8'd0) begin
      exp_q = 16'hFFFF; exp_r = 8'd0; exp_dz = 1'b1; exp_lat = 0;
    end else begin
      exp_q = dvd / {8'd0, b}; exp_r = 8'(dvd % {8'd0, b}); exp_dz = 1'b0; exp_lat = 16;
    end
    @(negedge clk);
    start = 1'b1; in_hi = hi; in_lo = lo; in_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    in_hi = 8'($urandom); in_lo = 8'($urandom); in_b = 8'($urandom);
    check("busy_accept", 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (repulse && n == 2) start = 1'b1;
      if (repulse && n == 4) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1) check("busy_run", 32'(busy), 32'd1);
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("quot_hi", 32'(out_hi), 32'(exp_q[15:8]));
    check("quot_lo", 32'(out_lo), 32'(exp_q[7:0]));
    check("rem", 32'(out_rem), 32'(exp_r));
    check("div_zero", 32'(div_zero), 32'(exp_dz));
    check("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("hold_lo", 32'(out_lo), 32'(exp_q[7:0]));
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; in_hi = '0; in_lo = '0; in_b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_outs", 32'({out_hi, out_lo, out_rem, div_zero}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(8'h00, 8'h64, 8'h07, 1'b0);
    run_op(8'hFF, 8'hFF, 8'hFF, 1'b0);
    run_op(8'h00, 8'h05, 8'h09, 1'b0);
    run_op(8'h12, 8'h34, 8'h00, 1'b0);
    run_op(8'h00, 8'h10, 8'h04, 1'b0);
    run_op(8'hAB, 8'hCD, 8'h03, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h01, 1'b0);

    // Abort mid-run: outputs clear at once and no done follows.
    @(negedge clk);
    start = 1'b1; in_hi = 8'h00; in_lo = 8'h64; in_b = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_outs", 32'({out_hi, out_lo, out_rem, div_zero}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_op(8'h00, 8'h64, 8'h07, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      if (i % 4 == 1) rb = 8'($urandom_range(1, 3));
      run_op(8'($urandom), 8'($urandom), rb, bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
